// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizing-register access arbiters.
package sync_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} sync_state_e;

  localparam int MAX_WRITERS = 16;

  // Grant-index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/std_sync_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module std_sync_rr_pick
  import sync_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  int j;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/std_sync_write_arbiter.sv
// Round-robin sharing of one std_sync_reg write port among N writers.
module std_sync_write_arbiter
  import sync_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in,
  input  logic [N-1:0]       write_en,
  output logic [N-1:0]       write_done,
  output logic [WIDTH-1:0]   reg_in,
  output logic               reg_write_en,
  input  logic               reg_write_done,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);
  sync_state_e      state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             busy;

  std_sync_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req   (write_en),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          grant <= pick_idx;
          state <= BUSY;
        end
        // Fairness pointer moves only when the register actually commits.
        BUSY: if (reg_write_done) begin
          state <= IDLE;
          ptr   <= (grant == IDX_W'(N - 1)) ? '0 : grant + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == BUSY);
  assign reg_write_en = busy;
  assign grant_valid  = busy;
  assign grant_idx    = busy ? grant : '0;
  assign reg_in       = busy ? in[int'(grant)*WIDTH +: WIDTH] : '0;
  assign write_done   = (busy && reg_write_done) ? (N'(1) << grant) : '0;
endmodule

// File: tb/tb_std_sync_write_arbiter.sv
// Bench for std_sync_write_arbiter with a behavioural arbiter and register model.
module tb_std_sync_write_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_bus;
  logic [N-1:0]   write_en;
  logic [N-1:0]   write_done;
  logic [W-1:0]   reg_in;
  logic           reg_write_en;
  logic           reg_write_done;
  logic           grant_valid;
  logic [1:0]     grant_idx;

  logic [W-1:0] din [N];

  int n_chk = 0;
  int n_err = 0;

  // arbiter model: who holds the port, and where the fairness search starts
  bit m_busy;
  int m_hold, m_ptr;
  // downstream register and reader
  bit       r_full;
  logic [W-1:0] r_val;
  bit       rd;
  // writer behaviour
  bit       auto_w, rearm;
  logic [N-1:0] dropped;
  logic [N-1:0] last_wd;
  bit       prev_gv;
  int       grants[$];
  logic [W-1:0] reads[$];

  std_sync_write_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .in             (in_bus),
    .write_en       (write_en),
    .write_done     (write_done),
    .reg_in         (reg_in),
    .reg_write_en   (reg_write_en),
    .reg_write_done (reg_write_done),
    .grant_valid    (grant_valid),
    .grant_idx      (grant_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = din[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance model, register and writers.
  task automatic step();
    bit n_busy; int n_hold, n_ptr; bit found;
    bit n_full, n_rwd; logic [W-1:0] n_val;
    logic [N-1:0] n_we; logic [W-1:0] n_din [N];
    #1;
    chk("grant_valid", 32'(grant_valid), 32'(m_busy));
    chk("grant_idx", 32'(grant_idx), m_busy ? m_hold : 0);
    chk("reg_write_en", 32'(reg_write_en), 32'(m_busy));
    chk("reg_in", reg_in, m_busy ? din[m_hold] : 32'h0);
    chk("write_done", 32'(write_done), (m_busy && reg_write_done) ? (32'd1 << m_hold) : 32'd0);
    if (grant_valid && !prev_gv) grants.push_back(int'(grant_idx));
    prev_gv = grant_valid;
    last_wd = write_done;

    n_busy = m_busy; n_hold = m_hold; n_ptr = m_ptr;
    if (reset) begin
      n_busy = 0; n_ptr = 0;
    end else if (m_busy) begin
      if (reg_write_done) begin n_busy = 0; n_ptr = (m_hold + 1) % N; end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && write_en[j]) begin found = 1; n_hold = j; end
      end
      if (found) n_busy = 1;
    end

    n_full = r_full; n_val = r_val; n_rwd = 0;
    if (reset) n_full = 0;
    else if (reg_write_en && !r_full) begin n_rwd = 1; n_full = 1; n_val = reg_in; end
    else if (rd && r_full) begin n_full = 0; reads.push_back(r_val); end

    n_we = write_en & ~write_done;
    if (rearm) n_we |= dropped;
    dropped = write_done;
    for (int k = 0; k < N; k++) begin
      n_din[k] = din[k];
      if (auto_w && !write_en[k] && !write_done[k] && $urandom_range(2) == 0) begin
        n_we[k] = 1'b1; n_din[k] = $urandom;
      end
    end

    @(posedge clk); #1;
    m_busy = n_busy; m_hold = n_hold; m_ptr = n_ptr;
    r_full = n_full; r_val = n_val; reg_write_done = n_rwd;
    write_en = n_we;
    for (int k = 0; k < N; k++) din[k] = n_din[k];
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    rd = 1; auto_w = 0; rearm = 0;
    for (int i = 0; i < 80; i++) begin
      if (write_en == 0 && !grant_valid && !r_full) begin ok = 1; break; end
      step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [N-1:0] exp);
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_wd != 0) begin ok = 1; break; end
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk(tag, 32'(last_wd), 32'(exp));
  endtask

  initial begin
    reset = 1; write_en = '0; reg_write_done = 0; rd = 0; auto_w = 0; rearm = 0;
    dropped = '0; prev_gv = 0; m_busy = 0; m_hold = 0; m_ptr = 0; r_full = 0; r_val = '0;
    for (int k = 0; k < N; k++) din[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_rwe", 32'(reg_write_en), 32'd0);
    chk("rst_wd", 32'(write_done), 32'd0);
    chk("rst_rin", reg_in, 32'd0);
    do_reset();

    // single writer, empty register
    write_en = 4'b0100; din[2] = 32'hDEADBEEF;
    step();
    chk("t1_rwe", 32'(reg_write_en), 32'd1);
    chk("t1_rin", reg_in, 32'hDEADBEEF);
    step();
    chk("t1_wd", 32'(write_done), 32'b0100);
    step();
    chk("t1_reg", r_val, 32'hDEADBEEF);
    write_en = 4'b1001;
    step();
    chk("t1_ptr3", 32'(grant_idx), 32'd3);
    drain("t1_drain");

    // all four writers from reset, reader draining
    do_reset();
    grants.delete(); reads.delete();
    for (int k = 0; k < N; k++) din[k] = 32'hA000_0000 + k;
    write_en = 4'b1111; rd = 1;
    drain("t2_drain");
    chk("t2_ngrants", grants.size(), 4);
    chk("t2_nreads", reads.size(), 4);
    for (int i = 0; i < 4 && i < grants.size() && i < reads.size(); i++) begin
      chk("t2_order", grants[i], i);
      chk("t2_data", reads[i], 32'hA000_0000 + i);
    end

    // full register blocks the commit
    do_reset();
    reads.delete();
    r_full = 1; r_val = 32'h1111_1111; rd = 0;
    write_en = 4'b0010; din[1] = 32'hCAFE_0001;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_idx", 32'(grant_idx), 32'd1);
      chk("t3_hold_rwe", 32'(reg_write_en), 32'd1);
      chk("t3_hold_wd", 32'(last_wd), 32'd0);
    end
    rd = 1; step(); rd = 0;
    wait_done("t3_wd", 4'b0010);
    chk("t3_read", reads.size() > 0 ? reads[0] : 32'hX, 32'h1111_1111);
    drain("t3_drain");

    // fairness between writers 0 and 3
    do_reset();
    grants.delete();
    rearm = 1; rd = 1; write_en = 4'b1001;
    for (int i = 0; i < 30; i++) step();
    chk("t4_ngrants", 32'(grants.size() >= 6), 32'd1);
    for (int i = 0; i < grants.size(); i++) chk("t4_alt", grants[i], (i % 2) ? 3 : 0);
    drain("t4_drain");

    // reset while BUSY on a full register
    do_reset();
    r_full = 1; r_val = 32'h2222_2222; rd = 0;
    write_en = 4'b0100; din[2] = 32'h0BAD_F00D;
    step(); step();
    chk("t5_busy_idx", 32'(grant_idx), 32'd2);
    reset = 1; step(); reset = 0;
    chk("t5_gv", 32'(grant_valid), 32'd0);
    chk("t5_wd", 32'(write_done), 32'd0);
    wait_done("t5_redo", 4'b0100);
    step();

    // stray commit pulse while IDLE; ptr stays at 3
    rd = 1; step();
    reg_write_done = 1;
    step();
    chk("t6_wd", 32'(last_wd), 32'd0);
    chk("t6_idle", 32'(grant_valid), 32'd0);
    write_en = 4'b1001;
    step();
    chk("t6_ptr", 32'(grant_idx), 32'd3);
    drain("t6_drain");

    // randomized traffic with random reader and occasional reset
    do_reset();
    auto_w = 1;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(1) == 1);
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 0;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
